// File: rtl/sampler_mixer_acc.sv
// sampler_mixer_acc: mixes up to MAX_VOICES AXI-Stream voice streams of one audio block into a
// register accumulator with guard bits, then drains the mixed block on the master port.
// Build option: define SAMPLER_MIXER_ACC_SAT_EN to saturate each output channel and report
// clipping on the clip flag; without it outputs wrap to SAMPLE_W bits and clip stays 0.
module sampler_mixer_acc #(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 16,
    parameter int BLOCK_LEN  = 64,
    parameter int MAX_VOICES = 16,
    parameter int TUSER_W    = 32,
    parameter int LAST_BIT   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic [TUSER_W-1:0]         s_axis_tuser,
    output logic                       s_axis_tready,
    output logic [NUM_CH*SAMPLE_W-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic [TUSER_W-1:0]         m_axis_tuser,
    input  logic                       m_axis_tready,
    output logic                       len_err,
    output logic                       voice_ovf,
    output logic                       clip
);
    localparam int TDATA_W = NUM_CH * SAMPLE_W;
    localparam int ACC_W   = SAMPLE_W + $clog2(MAX_VOICES);
    localparam int RD_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int WR_W    = $clog2(BLOCK_LEN + 1);
    localparam int VC_W    = $clog2(MAX_VOICES + 1);

`ifdef SAMPLER_MIXER_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

    typedef enum logic {RECEIVE, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [WR_W-1:0]      wr_idx_reg;
    logic [RD_W-1:0]      rd_idx_reg;
    logic [VC_W-1:0]      voices_reg;
    logic [BLOCK_LEN-1:0] valid_reg;
    logic                 len_err_reg, voice_ovf_reg, clip_reg;

    logic                 stop_beat, rx_beat, in_range, voices_full, do_sum;
    logic                 out_hs, drain_done, rd_valid;
    logic [RD_W-1:0]      wr_sel;
    logic [NUM_CH-1:0]    ch_sat;
    logic [TDATA_W-1:0]   mix_data;
    logic [31:0]          voices_wide;
    logic [7:0]           voices_cnt8;

    // Handshake decode; wr_idx parks at BLOCK_LEN so overlong streams are recognised and dropped
    always_comb begin
        stop_beat     = s_axis_tvalid && (s_axis_tuser == {TUSER_W{1'b1}});
        s_axis_tready = (state_reg == RECEIVE) || stop_beat;
        rx_beat       = s_axis_tvalid && (state_reg == RECEIVE) && !stop_beat;
        in_range      = wr_idx_reg < WR_W'(BLOCK_LEN);
        voices_full   = voices_reg == VC_W'(MAX_VOICES);
        do_sum        = rx_beat && in_range && !voices_full;
        wr_sel        = wr_idx_reg[RD_W-1:0];
        out_hs        = (state_reg == DRAIN) && m_axis_tready;
        drain_done    = out_hs && (rd_idx_reg == RD_W'(BLOCK_LEN - 1));
        rd_valid      = valid_reg[rd_idx_reg];
    end

    // Next state: a stop beat aborts from either state and wins over a block-ending tlast
    always_comb begin
        state_next = state_reg;
        if (stop_beat) begin
            state_next = RECEIVE;
        end else if (rx_beat && s_axis_tlast && s_axis_tuser[LAST_BIT]) begin
            state_next = DRAIN;
        end else if (drain_done) begin
            state_next = RECEIVE;
        end
    end

    // Master-side outputs follow the state register, so an abort drops tvalid on the next cycle
    always_comb begin
        voices_wide   = 32'(voices_reg);
        voices_cnt8   = (voices_wide > 32'd255) ? 8'hFF : voices_wide[7:0];
        m_axis_tvalid = (state_reg == DRAIN);
        m_axis_tlast  = (state_reg == DRAIN) && (rd_idx_reg == RD_W'(BLOCK_LEN - 1));
        m_axis_tdata  = (state_reg == DRAIN) ? mix_data : '0;
        m_axis_tuser  = (state_reg == DRAIN) ? TUSER_W'(voices_cnt8) : '0;
        len_err       = len_err_reg;
        voice_ovf     = voice_ovf_reg;
        clip          = clip_reg;
    end

    // Control state: indices, voice count, per-entry valid bits and sticky block flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RECEIVE;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            voices_reg    <= '0;
            valid_reg     <= '0;
            len_err_reg   <= 1'b0;
            voice_ovf_reg <= 1'b0;
            clip_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (stop_beat || drain_done) begin
                wr_idx_reg    <= '0;
                rd_idx_reg    <= '0;
                voices_reg    <= '0;
                valid_reg     <= '0;
                len_err_reg   <= 1'b0;
                voice_ovf_reg <= 1'b0;
                clip_reg      <= 1'b0;
            end else begin
                if (rx_beat) begin
                    if (s_axis_tlast) begin
                        wr_idx_reg <= '0;
                        if (!voices_full) begin
                            voices_reg <= voices_reg + 1'b1;
                        end
                        if (wr_idx_reg != WR_W'(BLOCK_LEN - 1)) begin
                            len_err_reg <= 1'b1;
                        end
                    end else if (in_range) begin
                        wr_idx_reg <= wr_idx_reg + 1'b1;
                    end else begin
                        len_err_reg <= 1'b1;
                    end
                    if (voices_full) begin
                        voice_ovf_reg <= 1'b1;
                    end
                    if (do_sum) begin
                        valid_reg[wr_sel] <= 1'b1;
                    end
                end
                if (out_hs) begin
                    rd_idx_reg <= rd_idx_reg + 1'b1;
                    if (|ch_sat) begin
                        clip_reg <= 1'b1;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [ACC_W-1:0] acc_mem [BLOCK_LEN];
            logic signed [ACC_W-1:0] in_ext;
            logic [SAMPLE_W-1:0]     ch_out;
            logic                    sat_flag;

            assign in_ext = ACC_W'($signed(s_axis_tdata[gi*SAMPLE_W +: SAMPLE_W]));

            // Read-modify-write: the first voice at an index overwrites stale data, later voices add
            always_ff @(posedge clk) begin
                if (do_sum) begin
                    acc_mem[wr_sel] <= valid_reg[wr_sel] ? (acc_mem[wr_sel] + in_ext) : in_ext;
                end
            end

`ifdef SAMPLER_MIXER_ACC_SAT_EN
            logic signed [ACC_W-1:0] rd_acc;
            assign rd_acc = acc_mem[rd_idx_reg];

            // Clamp the guard-bit sum to the sample range; untouched entries read as silence
            always_comb begin
                ch_out   = rd_acc[SAMPLE_W-1:0];
                sat_flag = 1'b0;
                if (rd_acc > SAT_HI) begin
                    ch_out   = SAT_HI[SAMPLE_W-1:0];
                    sat_flag = 1'b1;
                end else if (rd_acc < SAT_LO) begin
                    ch_out   = SAT_LO[SAMPLE_W-1:0];
                    sat_flag = 1'b1;
                end
                if (!rd_valid) begin
                    ch_out   = '0;
                    sat_flag = 1'b0;
                end
            end
`else
            // Legacy wrap: keep only the low sample bits; untouched entries read as silence
            always_comb begin
                ch_out   = rd_valid ? acc_mem[rd_idx_reg][SAMPLE_W-1:0] : '0;
                sat_flag = 1'b0;
            end
`endif

            assign mix_data[gi*SAMPLE_W +: SAMPLE_W] = ch_out;
            assign ch_sat[gi] = sat_flag;
        end
    endgenerate

endmodule

// File: tb/tb_sampler_mixer_acc.sv
// tb_sampler_mixer_acc: randomized scoreboard bench for sampler_mixer_acc.
// The driver pushes expected mixed blocks computed from plain integer sums; a monitor pops and
// compares on every master handshake.
module tb_sampler_mixer_acc;
    localparam int NC = 2;
    localparam int SW = 16;
    localparam int BL = 64;
    localparam int MV = 16;
    localparam int TW = 32;
    localparam int LB = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [TW-1:0] s_tuser;
    logic [31:0]   m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [TW-1:0] m_tuser;
    logic          len_err, voice_ovf, clip;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] user;
        logic        len_err;
        logic        ovf;
        logic        clip;
    } exp_t;
    exp_t exp_q[$];

    int m_acc [0:BL-1][0:NC-1];
    bit m_valid [0:BL-1];
    int m_voices;
    bit m_len_err, m_ovf;
    bit hold_ready = 1'b0;

    sampler_mixer_acc #(
        .NUM_CH(NC), .SAMPLE_W(SW), .BLOCK_LEN(BL), .MAX_VOICES(MV), .TUSER_W(TW), .LAST_BIT(LB)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .len_err(len_err), .voice_ovf(voice_ovf), .clip(clip)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < BL; i++) begin
            m_valid[i] = 1'b0;
            for (int c = 0; c < NC; c++) m_acc[i][c] = 0;
        end
        m_voices  = 0;
        m_len_err = 1'b0;
        m_ovf     = 1'b0;
    endfunction

    // Expected block: per-index sums formatted to SW bits, flags fixed for the whole block
    function automatic void push_block();
        exp_t e;
        bit   clip_seen;
        bit   any_sat;
        int   a, o;
        clip_seen = 1'b0;
        for (int i = 0; i < BL; i++) begin
            any_sat = 1'b0;
            e.data  = '0;
            for (int c = 0; c < NC; c++) begin
                a = m_valid[i] ? m_acc[i][c] : 0;
`ifdef SAMPLER_MIXER_ACC_SAT_EN
                if (a > 32767) begin
                    o = 32767; any_sat = 1'b1;
                end else if (a < -32768) begin
                    o = -32768; any_sat = 1'b1;
                end else begin
                    o = a;
                end
`else
                o = a & 32'hFFFF;
`endif
                e.data[c*SW +: SW] = SW'(o);
            end
            e.last    = (i == BL - 1);
            e.user    = (m_voices > 255) ? 32'd255 : 32'(m_voices);
            e.len_err = m_len_err;
            e.ovf     = m_ovf;
            e.clip    = clip_seen;
            exp_q.push_back(e);
            clip_seen |= any_sat;
        end
        model_clear();
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic lst, input logic [31:0] u);
        int waitc;
        @(negedge clk);
        s_tdata  = d;
        s_tlast  = lst;
        s_tuser  = u;
        s_tvalid = 1'b1;
        waitc    = 0;
        #4;
        while (!s_tready) begin
            waitc++;
            if (waitc > 200) begin
                checks++; errors++;
                $display("FAIL s_tready_timeout: got 0 required 1 within 200 cycles");
                break;
            end
            @(negedge clk);
            #4;
        end
        @(posedge clk);
    endtask

    // mode 0: ramp on all channels, 1: constants c0/c1, 2: random signed samples
    task automatic send_stream(input int nbeats, input int mode, input int c0, input int c1, input bit final_blk);
        bit          ovf_s;
        int          v [0:NC-1];
        logic [31:0] d, u;
        logic        lst;
        ovf_s = (m_voices >= MV);
        for (int i = 0; i < nbeats; i++) begin
            d = '0;
            for (int c = 0; c < NC; c++) begin
                case (mode)
                    0:       v[c] = i;
                    1:       v[c] = (c == 0) ? c0 : c1;
                    default: v[c] = int'($urandom_range(0, 65535)) - 32768;
                endcase
                d[c*SW +: SW] = SW'(v[c]);
            end
            lst   = (i == nbeats - 1);
            u     = $urandom;
            u[LB] = 1'b0;
            if (lst && final_blk) begin
                u[LB] = 1'b1;
                u[31] = 1'b0;
            end
            if (ovf_s) begin
                m_ovf = 1'b1;
            end else if (i < BL) begin
                for (int c = 0; c < NC; c++) m_acc[i][c] = (m_valid[i] ? m_acc[i][c] : 0) + v[c];
                m_valid[i] = 1'b1;
            end
            send_beat(d, lst, u);
        end
        if (nbeats != BL) m_len_err = 1'b1;
        if (!ovf_s) m_voices++;
        $display("stream: %0d beats, mode %0d, final %0d", nbeats, mode, final_blk);
        if (final_blk) push_block();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain_timeout: got %0d beats outstanding required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #4;
        check({tag, "_post_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_post_len_err"}, len_err, 1'b0);
        check({tag, "_post_voice_ovf"}, voice_ovf, 1'b0);
        $display("block %s drained", tag);
    endtask

    // Downstream ready: random back-pressure unless a test pins it low
    initial begin
        m_tready = 1'b0;
        forever begin
            @(negedge clk);
            m_tready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < 70);
        end
    end

    // Monitor: one scoreboard pop per master handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got data %0h required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", m_tdata, e.data);
                    check("m_tlast", m_tlast, e.last);
                    check("m_tuser", m_tuser, e.user);
                    check("len_err", len_err, e.len_err);
                    check("voice_ovf", voice_ovf, e.ovf);
                    check("clip", clip, e.clip);
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nb, n;
        logic [31:0] rnd;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        s_tdata  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        #4;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 32'h0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 32'h0);
        check("rst_flags", {len_err, voice_ovf, clip}, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        // Single voice ramp passes through unchanged
        send_stream(BL, 0, 0, 0, 1'b1);
        wait_drain("ramp");

        // Three constant voices
        send_stream(BL, 1, 100, 100, 1'b0);
        send_stream(BL, 1, 200, 200, 1'b0);
        send_stream(BL, 1, -50, -50, 1'b1);
        wait_drain("three_voice");

        // Overflowing pair: saturates or wraps depending on build
        send_stream(BL, 1, 32'h7000, 32'h7000, 1'b0);
        send_stream(BL, 1, 32'h7000, 32'h7000, 1'b1);
        wait_drain("overflow_pair");

        // Short first voice
        send_stream(10, 2, 0, 0, 1'b0);
        send_stream(BL, 2, 0, 0, 1'b1);
        wait_drain("short_voice");

        // Random blocks, one containing an overlong stream
        for (int b = 0; b < 4; b++) begin
            nv = $urandom_range(1, 5);
            for (int v = 0; v < nv; v++) begin
                nb = (b == 2 && v == 0) ? BL + 6 : BL;
                send_stream(nb, 2, 0, 0, v == nv - 1);
            end
            wait_drain("random");
        end

        // Seventeen voices with a sixteen-voice accumulator
        for (int v = 0; v < MV + 1; v++) send_stream(BL, 2, 0, 0, v == MV);
        wait_drain("voice_ovf");

        // Stop beat in the middle of a drain
        send_stream(BL, 2, 0, 0, 1'b0);
        send_stream(BL, 2, 0, 0, 1'b1);
        n = 0;
        while (exp_q.size() > BL - 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL stop_wait_timeout: got %0d beats outstanding required <= %0d", exp_q.size(), BL - 6);
        end
        @(posedge clk);
        #1 hold_ready = 1'b1;
        @(negedge clk);
        rnd      = $urandom;
        s_tdata  = rnd;
        s_tlast  = rnd[0];
        s_tuser  = '1;
        s_tvalid = 1'b1;
        #4;
        check("stop_drain_tready", s_tready, 1'b1);
        check("stop_drain_tvalid_pre", m_tvalid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        #4;
        check("stop_drain_tvalid_drop", m_tvalid, 1'b0);
        exp_q.delete();
        hold_ready = 1'b0;
        model_clear();
        $display("stop beat issued during drain");
        send_stream(BL, 2, 0, 0, 1'b0);
        send_stream(BL, 2, 0, 0, 1'b1);
        wait_drain("after_stop_drain");

        // Stop beat while receiving, then a clean block
        send_stream(BL, 2, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) send_beat($urandom, 1'b0, 32'h0);
        send_beat($urandom, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        s_tvalid = 1'b0;
        #4;
        check("stop_rx_tvalid", m_tvalid, 1'b0);
        model_clear();
        $display("stop beat issued during receive");
        send_stream(BL, 2, 0, 0, 1'b0);
        send_stream(BL, 2, 0, 0, 1'b1);
        wait_drain("after_stop_rx");

        // Reset in the middle of a block, then a clean block
        send_stream(10, 2, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 32'h0);
        @(negedge clk);
        s_tvalid = 1'b0;
        #4;
        check("pre_reset_len_err", len_err, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #4;
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_m_tdata", m_tdata, 32'h0);
        check("midrst_m_tuser", m_tuser, 32'h0);
        check("midrst_flags", {len_err, voice_ovf, clip}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        $display("reset applied during receive");
        send_stream(BL, 1, 1234, -4321, 1'b1);
        wait_drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
